// File: rtl/clock_ctrl_pkg.sv
// Shared types and command mapping for the clock input front end.
// Modes, command codes, key FSM states and the key-to-command map.
package clock_ctrl_pkg;

  typedef enum logic [2:0] {
    M_RUN        = 3'd0,
    M_SET_TIME   = 3'd1,
    M_STOPWATCH  = 3'd2,
    M_TIMER      = 3'd3,
    M_SET_TIMER  = 3'd4,
    M_ALARM_VIEW = 3'd5,
    M_SET_ALARM  = 3'd6
  } mode_e;

  typedef enum logic [3:0] {
    C_NONE        = 4'd0,
    C_INC_SEC     = 4'd1,
    C_INC_MIN     = 4'd2,
    C_INC_HR      = 4'd3,
    C_SW_START    = 4'd4,
    C_SW_STOP     = 4'd5,
    C_SW_CLEAR    = 4'd6,
    C_TMR_START   = 4'd7,
    C_TMR_STOP    = 4'd8,
    C_TMR_CLEAR   = 4'd9,
    C_TMR_INC_SEC = 4'd10,
    C_TMR_INC_MIN = 4'd11,
    C_TMR_INC_HR  = 4'd12,
    C_AL_INC_MIN  = 4'd13,
    C_AL_INC_HR   = 4'd14,
    C_ALARM_ACK   = 4'd15
  } cmd_e;

  typedef enum logic [1:0] {
    K_IDLE,
    K_PRESSED,
    K_REPEAT,
    K_LOCKED
  } key_st_e;

  function automatic cmd_e cmd_map(mode_e m, logic [1:0] k);
    cmd_e c;
    c = C_NONE;
    case (m)
      M_SET_TIME:
        c = (k == 2'd0) ? C_INC_MIN :
            (k == 2'd1) ? C_INC_HR : C_INC_SEC;
      M_STOPWATCH:
        c = (k == 2'd0) ? C_SW_CLEAR :
            (k == 2'd1) ? C_SW_STOP : C_SW_START;
      M_TIMER:
        c = (k == 2'd0) ? C_TMR_CLEAR :
            (k == 2'd1) ? C_TMR_STOP : C_TMR_START;
      M_SET_TIMER:
        c = (k == 2'd0) ? C_TMR_INC_MIN :
            (k == 2'd1) ? C_TMR_INC_HR : C_TMR_INC_SEC;
      M_SET_ALARM:
        c = (k == 2'd0) ? C_AL_INC_MIN :
            (k == 2'd1) ? C_AL_INC_HR : C_ALARM_ACK;
      default:
        c = (k == 2'd2) ? C_ALARM_ACK : C_NONE;
    endcase
    return c;
  endfunction

  function automatic logic is_repeatable(cmd_e c);
    return c inside {C_INC_SEC, C_INC_MIN, C_INC_HR,
                     C_TMR_INC_SEC, C_TMR_INC_MIN,
                     C_TMR_INC_HR, C_AL_INC_MIN,
                     C_AL_INC_HR};
  endfunction

endpackage

// File: rtl/clock_input_controller_key.sv
// One push-button: 2-flop synchronizer, debounce and press/repeat FSM.
// o_rep marks events produced by auto-repeat rather than the press.
module key_conditioner
  import clock_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 500_000,
  parameter int REPEAT_DELAY_CYCLES = 25_000_000,
  parameter int REPEAT_RATE_CYCLES  = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  input  logic i_lock,
  output logic o_held,
  output logic o_evt,
  output logic o_rep
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES)
                      ? REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [DW-1:0] DB_M1 = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_M1 = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] RATE_M1 = RW'(REPEAT_RATE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic [DW-1:0] r_dcnt;
  logic          r_held;
  key_st_e       r_st;
  logic [RW-1:0] r_rcnt;
  logic          r_evt;
  logic          r_rep;
  logic          w_lvl;
  logic          w_acc;

  // Counting only while the level differs from the held state means any
  // bounce back to the held level clears the count.
  assign w_lvl = ~r_s2;
  assign w_acc = (w_lvl != r_held) && (r_dcnt == DB_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_dcnt <= '0;
      r_held <= 1'b0;
      r_st   <= K_IDLE;
      r_rcnt <= '0;
      r_evt  <= 1'b0;
      r_rep  <= 1'b0;
    end else begin
      r_s1  <= i_key_n;
      r_s2  <= r_s1;
      r_evt <= 1'b0;
      r_rep <= 1'b0;
      if (w_lvl == r_held) begin
        r_dcnt <= '0;
      end else if (w_acc) begin
        r_dcnt <= '0;
        r_held <= w_lvl;
      end else begin
        r_dcnt <= r_dcnt + DW'(1);
      end
      unique case (r_st)
        K_IDLE: begin
          if (w_acc && w_lvl) begin
            r_rcnt <= '0;
            if (i_lock) begin
              r_st <= K_LOCKED;
            end else begin
              r_st  <= K_PRESSED;
              r_evt <= 1'b1;
            end
          end
        end
        K_PRESSED, K_REPEAT: begin
          if (w_acc) begin
            r_st <= K_IDLE;
          end else if (i_lock) begin
            r_st <= K_LOCKED;
          end else if (r_rcnt == ((r_st == K_PRESSED) ? DLY_M1 : RATE_M1)) begin
            r_st   <= K_REPEAT;
            r_rcnt <= '0;
            r_evt  <= 1'b1;
            r_rep  <= 1'b1;
          end else begin
            r_rcnt <= r_rcnt + RW'(1);
          end
        end
        K_LOCKED: begin
          if (w_acc) r_st <= K_IDLE;
        end
        default: r_st <= K_IDLE;
      endcase
    end
  end

  assign o_held = r_held;
  assign o_evt  = r_evt;
  assign o_rep  = r_rep;

endmodule

// File: rtl/clock_input_controller.sv
// Input front end: key conditioning, mode decode, command arbiter, 1 Hz tick.
// Issues at most one command per cycle, KEY1 first.
module clock_input_controller
  import clock_ctrl_pkg::*;
#(
  parameter int CLK_HZ              = 50_000_000,
  parameter int DEBOUNCE_CYCLES     = 500_000,
  parameter int REPEAT_DELAY_CYCLES = 25_000_000,
  parameter int REPEAT_RATE_CYCLES  = 5_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [2:0] key_n,
  input  logic [5:0] sw,
  output logic       tick_1hz,
  output logic [2:0] mode,
  output logic       cmd_valid,
  output logic [3:0] cmd,
  output logic [2:0] key_held
);

  localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [TW-1:0] T_MAX = TW'(CLK_HZ - 1);

  logic [5:0]    r_sw1;
  logic [5:0]    r_sw2;
  mode_e         r_mode;
  mode_e         r_mode_d;
  mode_e         w_mode;
  logic          w_chg;
  logic [2:0]    w_evt;
  logic [2:0]    w_rep;
  logic [2:0]    w_req;
  logic [2:0]    w_act;
  logic [2:0]    w_gnt;
  logic [2:0]    r_pend;
  cmd_e          w_map [3];
  cmd_e          w_gcmd;
  cmd_e          r_cmd;
  logic          r_valid;
  logic [TW-1:0] r_tcnt;
  logic          r_tick;

  assign w_chg = (r_mode != r_mode_d);

  for (genvar g = 0; g < 3; g++) begin : g_key
    key_conditioner #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES)
    ) u_key (
      .clk    (CLOCK_50),
      .rst_n  (reset_n),
      .i_key_n(key_n[g]),
      .i_lock (w_chg),
      .o_held (key_held[g]),
      .o_evt  (w_evt[g]),
      .o_rep  (w_rep[g])
    );
    assign w_map[g] = cmd_map(r_mode, 2'(g));
    // Unmapped events and repeats of one-shot commands never reach pending.
    assign w_req[g] = w_evt[g] & (w_map[g] != C_NONE)
                    & (~w_rep[g] | is_repeatable(w_map[g]));
  end

  always_comb begin
    w_mode = M_RUN;
    priority case (1'b1)
      r_sw2[5]: w_mode = M_SET_ALARM;
      r_sw2[4]: w_mode = M_ALARM_VIEW;
      r_sw2[3]: w_mode = M_SET_TIMER;
      r_sw2[2]: w_mode = M_TIMER;
      r_sw2[1]: w_mode = M_STOPWATCH;
      r_sw2[0]: w_mode = M_SET_TIME;
      default:  w_mode = M_RUN;
    endcase
  end

  assign w_act = r_pend | w_req;
  assign w_gnt = w_act & (~w_act + 3'd1);

  always_comb begin
    w_gcmd = C_NONE;
    unique case (1'b1)
      w_gnt[0]: w_gcmd = w_map[0];
      w_gnt[1]: w_gcmd = w_map[1];
      w_gnt[2]: w_gcmd = w_map[2];
      default:  w_gcmd = C_NONE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_sw1    <= '0;
      r_sw2    <= '0;
      r_mode   <= M_RUN;
      r_mode_d <= M_RUN;
      r_pend   <= '0;
      r_valid  <= 1'b0;
      r_cmd    <= C_NONE;
      r_tcnt   <= '0;
      r_tick   <= 1'b0;
    end else begin
      r_sw1    <= sw;
      r_sw2    <= r_sw1;
      r_mode   <= w_mode;
      r_mode_d <= r_mode;
      if (w_chg) begin
        r_pend  <= '0;
        r_valid <= 1'b0;
        r_cmd   <= C_NONE;
      end else begin
        r_pend  <= w_act & ~w_gnt;
        r_valid <= |w_gnt;
        r_cmd   <= w_gcmd;
      end
      r_tcnt <= (r_tcnt == T_MAX) ? '0 : r_tcnt + TW'(1);
      r_tick <= (r_tcnt == T_MAX);
    end
  end

  assign tick_1hz  = r_tick;
  assign mode      = r_mode;
  assign cmd_valid = r_valid;
  assign cmd       = r_cmd;

endmodule

// File: tb/tb_clock_input_controller.sv
// Directed bench for clock_input_controller with scaled timing parameters.
module tb_clock_input_controller;

  typedef struct {
    logic [5:0] sw;
    int         k;
    logic [2:0] m;
    logic       v;
    logic [3:0] c;
  } vec_t;

  typedef struct {
    int         t;
    logic [3:0] c;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] key_n;
  logic [5:0] sw;
  logic       tick_1hz;
  logic [2:0] mode;
  logic       cmd_valid;
  logic [3:0] cmd;
  logic [2:0] key_held;

  int  cyc = 0;
  int  n_pass = 0;
  int  n_tot = 0;
  ev_t q[$];
  vec_t tbl[21];

  clock_input_controller #(
    .CLK_HZ(10),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY_CYCLES(20),
    .REPEAT_RATE_CYCLES(5)
  ) dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .key_n    (key_n),
    .sw       (sw),
    .tick_1hz (tick_1hz),
    .mode     (mode),
    .cmd_valid(cmd_valid),
    .cmd      (cmd),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmd_valid) begin
      q.push_back('{cyc, cmd});
    end else begin
      n_tot++;
      if (cmd == 4'd0) n_pass++;
      else $display("FAIL idle_cmd: cmd=%0d while cmd_valid=0, need 0", cmd);
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int act, int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, need %0d", nm, act, exp);
  endtask

  task automatic expect_ev(string nm, int i, int t0, int off, logic [3:0] c);
    n_tot++;
    if (i < q.size() && q[i].t - t0 == off && q[i].c == c) begin
      n_pass++;
    end else if (i < q.size()) begin
      $display("FAIL %s: got cmd %0d at +%0d, need cmd %0d at +%0d",
               nm, q[i].c, q[i].t - t0, c, off);
    end else begin
      $display("FAIL %s: got no command, need cmd %0d at +%0d", nm, c, off);
    end
  endtask

  initial begin
    int t;
    tbl[0]  = '{6'b000000, 0, 3'd0, 1'b0, 4'd0};
    tbl[1]  = '{6'b000000, 1, 3'd0, 1'b0, 4'd0};
    tbl[2]  = '{6'b000000, 2, 3'd0, 1'b1, 4'd15};
    tbl[3]  = '{6'b000001, 0, 3'd1, 1'b1, 4'd2};
    tbl[4]  = '{6'b000001, 1, 3'd1, 1'b1, 4'd3};
    tbl[5]  = '{6'b000001, 2, 3'd1, 1'b1, 4'd1};
    tbl[6]  = '{6'b000011, 0, 3'd2, 1'b1, 4'd6};
    tbl[7]  = '{6'b000010, 1, 3'd2, 1'b1, 4'd5};
    tbl[8]  = '{6'b000010, 2, 3'd2, 1'b1, 4'd4};
    tbl[9]  = '{6'b000110, 0, 3'd3, 1'b1, 4'd9};
    tbl[10] = '{6'b000100, 1, 3'd3, 1'b1, 4'd8};
    tbl[11] = '{6'b000100, 2, 3'd3, 1'b1, 4'd7};
    tbl[12] = '{6'b001000, 0, 3'd4, 1'b1, 4'd11};
    tbl[13] = '{6'b001000, 1, 3'd4, 1'b1, 4'd12};
    tbl[14] = '{6'b001001, 2, 3'd4, 1'b1, 4'd10};
    tbl[15] = '{6'b011000, 0, 3'd5, 1'b0, 4'd0};
    tbl[16] = '{6'b010000, 1, 3'd5, 1'b0, 4'd0};
    tbl[17] = '{6'b010000, 2, 3'd5, 1'b1, 4'd15};
    tbl[18] = '{6'b100000, 0, 3'd6, 1'b1, 4'd13};
    tbl[19] = '{6'b110000, 1, 3'd6, 1'b1, 4'd14};
    tbl[20] = '{6'b100000, 2, 3'd6, 1'b1, 4'd15};

    reset_n = 1'b0;
    key_n   = 3'b111;
    sw      = 6'd0;
    step(3);
    chk("rst_tick", int'(tick_1hz), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_cmd", int'(cmd), 0);
    chk("rst_held", int'(key_held), 0);
    reset_n = 1'b1;
    step(5);

    foreach (tbl[i]) begin
      sw = tbl[i].sw;
      step(8);
      chk($sformatf("tbl%0d_mode", i), int'(mode), int'(tbl[i].m));
      q.delete();
      t = cyc;
      key_n[tbl[i].k] = 1'b0;
      step(12);
      key_n = 3'b111;
      step(12);
      chk($sformatf("tbl%0d_count", i), q.size(), tbl[i].v ? 1 : 0);
      if (tbl[i].v) expect_ev($sformatf("tbl%0d_cmd", i), 0, t, 7, tbl[i].c);
    end

    // Bounce on KEY1 in SET_TIME.
    sw = 6'b000001;
    step(8);
    q.delete();
    for (int i = 0; i < 6; i++) begin
      key_n[0] = (i % 2 == 1);
      step(2);
    end
    t = cyc;
    key_n[0] = 1'b0;
    step(5);
    chk("bounce_held_early", int'(key_held[0]), 0);
    step(1);
    chk("bounce_held", int'(key_held[0]), 1);
    chk("bounce_valid_early", int'(cmd_valid), 0);
    step(1);
    chk("bounce_valid", int'(cmd_valid), 1);
    step(6);
    key_n = 3'b111;
    step(12);
    chk("bounce_count", q.size(), 1);
    expect_ev("bounce_cmd", 0, t, 7, 4'd2);

    // Auto-repeat on KEY2 held 60 cycles.
    q.delete();
    t = cyc;
    key_n[1] = 1'b0;
    step(60);
    key_n = 3'b111;
    step(20);
    chk("rep_count", q.size(), 9);
    expect_ev("rep_0", 0, t, 7, 4'd3);
    for (int i = 1; i < 9; i++)
      expect_ev($sformatf("rep_%0d", i), i, t, 22 + 5 * i, 4'd3);

    // Simultaneous KEY1 and KEY3 in STOPWATCH.
    sw = 6'b000010;
    step(8);
    q.delete();
    t = cyc;
    key_n = 3'b010;
    step(40);
    key_n = 3'b111;
    step(15);
    chk("cont_count", q.size(), 2);
    expect_ev("cont_first", 0, t, 7, 4'd6);
    expect_ev("cont_second", 1, t, 8, 4'd4);

    // Priority decode with several switches on.
    sw = 6'd0;
    step(8);
    sw = 6'b100101;
    step(2);
    chk("prio_mode_early", int'(mode), 0);
    step(1);
    chk("prio_mode", int'(mode), 6);
    step(5);
    q.delete();
    t = cyc;
    key_n[2] = 1'b0;
    step(30);
    key_n = 3'b111;
    step(12);
    chk("prio_count", q.size(), 1);
    expect_ev("prio_cmd", 0, t, 7, 4'd15);

    // Mode change while KEY2 repeats.
    sw = 6'b000001;
    step(8);
    q.delete();
    t = cyc;
    key_n[1] = 1'b0;
    step(28);
    sw = 6'b000010;
    step(30);
    key_n = 3'b111;
    step(15);
    chk("lock_count", q.size(), 2);
    expect_ev("lock_press", 0, t, 7, 4'd3);
    expect_ev("lock_rep", 1, t, 27, 4'd3);
    q.delete();
    t = cyc;
    key_n[1] = 1'b0;
    step(12);
    key_n = 3'b111;
    step(12);
    chk("lock_next_count", q.size(), 1);
    expect_ev("lock_next_cmd", 0, t, 7, 4'd5);

    // Mode change into another repeatable mapping must still lock the key.
    sw = 6'b000001;
    step(8);
    q.delete();
    t = cyc;
    key_n[0] = 1'b0;
    step(28);
    sw = 6'b001000;
    step(30);
    key_n = 3'b111;
    step(15);
    chk("lock2_count", q.size(), 2);
    expect_ev("lock2_rep", 1, t, 27, 4'd2);

    // Reset mid-repeat, then tick alignment.
    sw = 6'b000001;
    step(8);
    key_n[1] = 1'b0;
    step(30);
    reset_n = 1'b0;
    key_n = 3'b111;
    sw = 6'd0;
    #1;
    chk("mid_rst_tick", int'(tick_1hz), 0);
    chk("mid_rst_mode", int'(mode), 0);
    chk("mid_rst_valid", int'(cmd_valid), 0);
    chk("mid_rst_cmd", int'(cmd), 0);
    chk("mid_rst_held", int'(key_held), 0);
    step(3);
    reset_n = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      step(1);
      chk($sformatf("tick_c%0d", k), int'(tick_1hz),
          (k == 10 || k == 20) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
